// File: rtl/enc_pkg.sv
// Shared encodings for the instruction encoder: immediate formats, NOP word,
// controller states and the signed immediate range limits.
package enc_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational scatter of a 32-bit immediate into I/S/B/J positions.
// ENC_RANGE_CHECK_EN enables range/alignment checks with NOP substitution.
module imm_packer
    import enc_pkg::*;
(
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] Imm,
    input  logic [6:0]  Opcode,
    input  logic [4:0]  Rd,
    input  logic [2:0]  Funct3,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    output logic [31:0] Instr,
    output logic        RangeErr
);

    logic [31:0] packed_word;

    always_comb begin
        packed_word = '0;
        case (ImmSrc)
            IMM_I:   packed_word = {Imm[11:0], Rs1, Funct3, Rd, Opcode};
            IMM_S:   packed_word = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode};
            IMM_B:   packed_word = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3,
                                    Imm[4:1], Imm[11], Opcode};
            default: packed_word = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Opcode};
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    function automatic logic imm_out_of_range(input logic [1:0] src,
                                              input logic signed [31:0] imm);
        logic bad;
        case (src)
            IMM_I, IMM_S: bad = (imm < IMM12_MIN) || (imm > IMM12_MAX);
            IMM_B:        bad = (imm < IMMB_MIN) || (imm > IMMB_MAX) || imm[0];
            default:      bad = (imm < IMMJ_MIN) || (imm > IMMJ_MAX) || imm[0];
        endcase
        return bad;
    endfunction

    logic signed [31:0] imm_s;
    assign imm_s    = Imm;
    assign RangeErr = imm_out_of_range(ImmSrc, imm_s);
    assign Instr    = RangeErr ? NOP_INSTR : packed_word;
`else
    // Upper immediate bits only matter to the range check.
    logic unused_imm;
    assign unused_imm = ^Imm[31:21];
    assign RangeErr   = 1'b0;
    assign Instr      = packed_word;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RISC-V instruction encoder: packer, 2-entry output FIFO,
// word-address counter and program FSM. Optional macro: ENC_RANGE_CHECK_EN.
module instr_encoder
    import enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic        InLast,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] Imm,
    input  logic [6:0]  Opcode,
    input  logic [4:0]  Rd,
    input  logic [2:0]  Funct3,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Instr,
    output logic [31:0] Addr,
    output logic        Done,
    output logic        ImmErr
);

    logic [31:0] enc_word_p0;
    logic        range_err_p0;

    imm_packer u_packer (
        .ImmSrc   (ImmSrc),
        .Imm      (Imm),
        .Opcode   (Opcode),
        .Rd       (Rd),
        .Funct3   (Funct3),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .Instr    (enc_word_p0),
        .RangeErr (range_err_p0)
    );

    // FIFO entry: {last, instr}
    logic [32:0] fifo_mem_p1 [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count, count_nxt;
    logic [31:0] index;
    logic        imm_err_q;
    enc_state_e  state, state_nxt;
    logic        push, pop, pop_last;

    assign InReady  = (count != 2'd2) && (state != ST_DONE);
    assign OutValid = (count != 2'd0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;
    assign pop_last = pop && fifo_mem_p1[rd_ptr][32];
    assign Instr    = OutValid ? fifo_mem_p1[rd_ptr][31:0] : 32'h0;
    assign Addr     = BASE_ADDR + (index << 2);
    assign Done     = (state == ST_DONE);
    assign ImmErr   = imm_err_q;

    // Stage p0 -> p1: encoded word enters the FIFO
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_p1[wr_ptr] <= {InLast, enc_word_p0};
    end

    always_comb begin
        count_nxt = count + {1'b0, push} - {1'b0, pop};
        state_nxt = state;
        case (state)
            ST_IDLE: if (push) state_nxt = ST_BUSY;
            ST_BUSY: if (pop_last) state_nxt = ST_DONE;
            default: begin
                // Words of the next program may already be queued.
                if (pop_last)
                    state_nxt = ST_DONE;
                else if (count_nxt != 2'd0)
                    state_nxt = ST_BUSY;
                else
                    state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            index     <= 32'h0;
            imm_err_q <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count_nxt;
            state  <= state_nxt;
            if (pop_last)
                index <= 32'h0;
            else if (pop)
                index <= index + 32'h1;
            if (push && range_err_p0)
                imm_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (BASE_ADDR = 0).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        InValid;
    logic        InReady;
    logic        InLast;
    logic [1:0]  ImmSrc;
    logic [31:0] Imm;
    logic [6:0]  Opcode;
    logic [4:0]  Rd;
    logic [2:0]  Funct3;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instr;
    logic [31:0] Addr;
    logic        Done;
    logic        ImmErr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .InLast   (InLast),
        .ImmSrc   (ImmSrc),
        .Imm      (Imm),
        .Opcode   (Opcode),
        .Rd       (Rd),
        .Funct3   (Funct3),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Instr    (Instr),
        .Addr     (Addr),
        .Done     (Done),
        .ImmErr   (ImmErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [6:0] op,
                         input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic last);
        InValid = 1'b1;
        ImmSrc  = src;
        Imm     = imm;
        Opcode  = op;
        Rd      = rd;
        Funct3  = f3;
        Rs1     = rs1;
        Rs2     = rs2;
        InLast  = last;
    endtask

    initial begin
        reset = 1'b1; InValid = 1'b0; InLast = 1'b0; ImmSrc = 2'b00; Imm = 32'h0;
        Opcode = 7'h0; Rd = 5'h0; Funct3 = 3'h0; Rs1 = 5'h0; Rs2 = 5'h0; OutReady = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_inready", {31'h0, InReady}, 32'h1);
        chk("rst_outvalid", {31'h0, OutValid}, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_addr", Addr, 32'h0);
        chk("rst_done", {31'h0, Done}, 32'h0);
        chk("rst_immerr", {31'h0, ImmErr}, 32'h0);

        // addi x1,x0,5 as a one-word program
        drive(2'b00, 32'd5, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b1);
        step();
        InValid = 1'b0;
        chk("addi_valid", {31'h0, OutValid}, 32'h1);
        chk("addi_instr", Instr, 32'h0050_0093);
        chk("addi_addr", Addr, 32'h0);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk("addi_done", {31'h0, Done}, 32'h1);
        chk("addi_done_addr", Addr, 32'h0);
        chk("addi_done_inready", {31'h0, InReady}, 32'h0);
        chk("addi_empty", {31'h0, OutValid}, 32'h0);
        step();
        chk("addi_done_clr", {31'h0, Done}, 32'h0);
        chk("addi_idle_inready", {31'h0, InReady}, 32'h1);

        // sw x2,8(x0) then beq x0,x0,-4
        drive(2'b01, 32'd8, 7'b0100011, 5'd0, 3'b010, 5'd0, 5'd2, 1'b0);
        step();
        drive(2'b10, 32'hFFFF_FFFC, 7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 1'b1);
        step();
        InValid = 1'b0;
        chk("sw_full_inready", {31'h0, InReady}, 32'h0);
        chk("sw_instr", Instr, 32'h0020_2423);
        chk("sw_addr", Addr, 32'h0);
        OutReady = 1'b1;
        step();
        chk("beq_instr", Instr, 32'hFE00_0EE3);
        chk("beq_addr", Addr, 32'h4);
        chk("beq_nodone", {31'h0, Done}, 32'h0);
        step();
        chk("beq_done", {31'h0, Done}, 32'h1);
        chk("beq_done_addr", Addr, 32'h0);
        step();

        // jal x1,8 then addi streamed with OutReady held high
        drive(2'b11, 32'd8, 7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 1'b0);
        step();
        chk("jal_instr", Instr, 32'h0080_00EF);
        chk("jal_addr", Addr, 32'h0);
        drive(2'b00, 32'd5, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b1);
        step();
        InValid = 1'b0;
        chk("pp_valid", {31'h0, OutValid}, 32'h1);
        chk("pp_instr", Instr, 32'h0050_0093);
        chk("pp_addr", Addr, 32'h4);
        step();
        chk("pp_done", {31'h0, Done}, 32'h1);
        OutReady = 1'b0;
        step();

        // Backpressure: three bundles with the consumer stalled
        drive(2'b00, 32'd1, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b0);
        step();
        drive(2'b00, 32'd2, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b0);
        step();
        drive(2'b00, 32'd3, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b1);
        chk("bp_inready_low", {31'h0, InReady}, 32'h0);
        step();
        chk("bp_hold_instr", Instr, 32'h0010_0093);
        chk("bp_hold_addr", Addr, 32'h0);
        OutReady = 1'b1;
        step();
        chk("bp_w2_instr", Instr, 32'h0020_0093);
        chk("bp_w2_addr", Addr, 32'h4);
        chk("bp_inready_back", {31'h0, InReady}, 32'h1);
        step();
        InValid = 1'b0;
        chk("bp_w3_instr", Instr, 32'h0030_0093);
        chk("bp_w3_addr", Addr, 32'h8);
        chk("bp_w3_valid", {31'h0, OutValid}, 32'h1);
        step();
        chk("bp_done", {31'h0, Done}, 32'h1);
        chk("bp_empty", {31'h0, OutValid}, 32'h0);
        OutReady = 1'b0;
        step();

        // I-type immediate just out of range
        drive(2'b00, 32'd2048, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b1);
        step();
        InValid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        chk("oor_instr", Instr, 32'h0000_0013);
        chk("oor_immerr", {31'h0, ImmErr}, 32'h1);
`else
        chk("oor_instr", Instr, 32'h8000_0093);
        chk("oor_immerr", {31'h0, ImmErr}, 32'h0);
`endif
        OutReady = 1'b1;
        step();
        chk("oor_done", {31'h0, Done}, 32'h1);
        step();

        // J-type lower bound is legal
        drive(2'b11, 32'hFFF0_0000, 7'b1101111, 5'd0, 3'b000, 5'd0, 5'd0, 1'b1);
        step();
        InValid = 1'b0;
        chk("jmin_instr", Instr, 32'h8000_006F);
        step();
        chk("jmin_done", {31'h0, Done}, 32'h1);
        step();
`ifdef ENC_RANGE_CHECK_EN
        chk("immerr_sticky", {31'h0, ImmErr}, 32'h1);
`else
        chk("immerr_sticky", {31'h0, ImmErr}, 32'h0);
`endif

        // Reset with two words queued
        OutReady = 1'b0;
        drive(2'b00, 32'd7, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b0);
        step();
        drive(2'b00, 32'd9, 7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 1'b0);
        step();
        InValid = 1'b0;
        chk("q2_valid", {31'h0, OutValid}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_outvalid", {31'h0, OutValid}, 32'h0);
        chk("mrst_addr", Addr, 32'h0);
        chk("mrst_inready", {31'h0, InReady}, 32'h1);
        chk("mrst_instr", Instr, 32'h0);
        chk("mrst_immerr", {31'h0, ImmErr}, 32'h0);
        step();
        chk("mrst_stay_empty", {31'h0, OutValid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
